// File: rtl/store_agu_pkg.sv
// store_agu_pkg: shared types and constants for the CGRA store path.
// Holds the datapath op-code constants, the store AGU state encoding
// and the pipeline stage-valid type.
package store_agu_pkg;

  // Datapath op-codes shared with the functional units.
  localparam logic [3:0] add_op = 4'd0;
  localparam logic [3:0] sub_op = 4'd1;
  localparam logic [3:0] mul_op = 4'd2;
  localparam logic [3:0] ld_op  = 4'd3;
  localparam logic [3:0] st_op  = 4'd4;

  // Store AGU sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } agu_state_e;

  // Valid flag that travels alongside each address pipeline stage.
  typedef logic stage_vld_t;

endpackage

// File: rtl/store_agu_if.sv
// store_agu_if: bundles the input data stream and the Mem write port.
// Stream: in_data/in_valid from the producer, in_ready back to it.
// Mem:    mem_addr/mem_wdata/mem_we from the AGU to the memory.
// Modports: master = producer/memory side, slave = store AGU side.
interface store_agu_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_we;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_addr,
    output mem_wdata,
    output mem_we
  );

endinterface

// File: rtl/store_addr_pipe.sv
// store_addr_pipe: two-stage address pipeline, stride*idx then base+prod.
// Latency 2 cycles from vld_i to mem_we_o; one element per cycle.
// No backpressure; en_i low holds both stages and masks the write strobe.
// Ports: clk_i/rst_i/en_i control; base_i/stride_i/idx_i/data_i/vld_i in;
//        v1_o (stage-1 occupancy), mem_addr_o/mem_wdata_o/mem_we_o out.
module store_addr_pipe
  import store_agu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] stride_i,
  input  logic [WIDTH-1:0] idx_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             vld_i,
  output logic             v1_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  output logic             mem_we_o
);

  // Stage 1: product and data
  logic [WIDTH-1:0] prod_d, prod_q;
  logic [WIDTH-1:0] d1_q;
  stage_vld_t       v1_q;

  // Stage 2: final address and data
  logic [WIDTH-1:0] addr_d, addr_q;
  logic [WIDTH-1:0] wdata_q;
  stage_vld_t       we_q;

  // Both results truncate to WIDTH, so addresses wrap modulo 2^WIDTH.
  always_comb begin
    prod_d = stride_i * idx_i;
    addr_d = base_i + prod_q;
  end

  // Data registers only load on a valid beat so the Mem port holds the
  // last written address/data between writes instead of toggling.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q  <= '0;
      d1_q    <= '0;
      v1_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (en_i) begin
      v1_q <= vld_i;
      if (vld_i) begin
        prod_q <= prod_d;
        d1_q   <= data_i;
      end
      we_q <= v1_q;
      if (v1_q) begin
        addr_q  <= addr_d;
        wdata_q <= d1_q;
      end
    end
  end

  assign v1_o        = v1_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  // A stalled write stays in we_q and fires once en_i returns.
  assign mem_we_o    = we_q & en_i;

endmodule

// File: rtl/store_agu.sv
// store_agu: streaming store AGU, writes element i to base + stride*i.
// Latency 2 cycles from stream transfer to Mem write; 1 element/cycle.
// Backpressure via in_ready only; Mem never stalls; en_i low freezes all.
// Ports: clk_i, rst_i (sync, active-high), en_i, start_i, base_i,
//        stride_i, count_i; bus (stream in + Mem write out, slave side);
//        busy_o (RUN/DRAIN), done_o (one-cycle end-of-sequence pulse).
module store_agu
  import store_agu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] stride_i,
  input  logic [WIDTH-1:0] count_i,
  store_agu_if.slave       bus,
  output logic             busy_o,
  output logic             done_o
);

  agu_state_e       state_q;
  logic [WIDTH-1:0] base_q, stride_q, count_q;
  // Element index; since it starts at 0 and steps once per transfer it
  // doubles as the accepted-beat count.
  logic [WIDTH-1:0] idx_q;
  logic [WIDTH-1:0] idx_inc;
  logic             busy_q, done_q;
  logic             in_ready;
  logic             xfer;
  logic             v1;

  assign idx_inc  = idx_q + WIDTH'(1);
  assign in_ready = (state_q == ST_RUN) & en_i & (idx_q < count_q);
  assign xfer     = bus.in_valid & in_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      stride_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (en_i) begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            base_q   <= base_i;
            stride_q <= stride_i;
            count_q  <= count_i;
            idx_q    <= '0;
            if (count_i == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            idx_q <= idx_inc;
            if (idx_inc == count_q) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Once stage 1 is empty, the stage-2 write (if any) retires on
          // this same edge, so the pipeline is empty after it.
          if (!v1) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  store_addr_pipe #(
    .WIDTH (WIDTH)
  ) u_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .base_i      (base_q),
    .stride_i    (stride_q),
    .idx_i       (idx_q),
    .data_i      (bus.in_data),
    .vld_i       (xfer),
    .v1_o        (v1),
    .mem_addr_o  (bus.mem_addr),
    .mem_wdata_o (bus.mem_wdata),
    .mem_we_o    (bus.mem_we)
  );

  assign bus.in_ready = in_ready;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
